// File: rtl/rgb_matrix_pkg.sv
// Shared definitions for the RGB LED matrix scanner: default geometry,
// PWM depth, blanking length, output polarity and the scan state encoding.
package rgb_matrix_pkg;

    localparam int DEF_ROWS       = 8;
    localparam int DEF_COLS       = 8;
    localparam int DEF_PWM_BITS   = 3;
    localparam int DEF_BLANK      = 1;
    localparam int DEF_ACTIVE_LOW = 1;

    // BLANK: rows forced off while the column line settles.
    // DRIVE: rows modulated by the PWM comparison.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/rgb_matrix_pwm_cmp.sv
// One colour, one column: each row is lit while its intensity exceeds the
// current PWM step. Produces raw "lit" bits; polarity is applied by the caller.
module rgb_matrix_pwm_cmp
    import rgb_matrix_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic [ROWS*PWM_BITS-1:0] level,
    input  logic [PWM_BITS-1:0]      p,
    output logic [ROWS-1:0]          lit
);

    // Unsigned magnitude compare per row: level 0 never lights, full scale always does.
    always_comb begin
        lit = '0;
        for (int r = 0; r < ROWS; r++) begin
            lit[r] = (level[r*PWM_BITS +: PWM_BITS] > p);
        end
    end

endmodule

// File: rtl/rgb_matrix_scanner.sv
// Column-multiplexed RGB LED matrix scanner with per-pixel PWM.
// A sequencer walks BLANK -> DRIVE for every column; a double buffer
// (shadow + active) takes new frames over a valid/ready handshake and only
// swaps at the frame boundary so a frame is never shown half old, half new.
// The sequencer registers hold the position of the cycle about to be shown;
// every output is a register loaded from that position.
module rgb_matrix_scanner
    import rgb_matrix_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int PWM_BITS   = DEF_PWM_BITS,
    parameter int BLANK      = DEF_BLANK,
    parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ROWS*COLS*PWM_BITS-1:0] pix_r,
    input  logic [ROWS*COLS*PWM_BITS-1:0] pix_g,
    input  logic [ROWS*COLS*PWM_BITS-1:0] pix_b,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [ROWS-1:0]               led_r,
    output logic [ROWS-1:0]               led_g,
    output logic [ROWS-1:0]               led_b,
    output logic [$clog2(COLS)-1:0]       led_com,
    output logic                          frame_start
);

    localparam int D        = (1 << PWM_BITS) - 1;
    localparam int CNT_MAX  = (BLANK > D) ? BLANK : D;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int COL_W    = $clog2(COLS);
    localparam int FRAME_W  = ROWS * COLS * PWM_BITS;
    localparam int COLUMN_W = ROWS * PWM_BITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(D - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROWS-1:0]  OFF        = (ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

    // Sequencer: position of the upcoming displayed cycle.
    state_t             state_p0;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt_p0;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [COL_W-1:0]   col_p0;
    logic [COL_W-1:0]   col_nxt;

    // High while the last DRIVE cycle of the last column is on display.
    logic               frame_last;

    // Frame storage.
    logic [FRAME_W-1:0] shadow_r;
    logic [FRAME_W-1:0] shadow_g;
    logic [FRAME_W-1:0] shadow_b;
    logic [FRAME_W-1:0] active_r;
    logic [FRAME_W-1:0] active_g;
    logic [FRAME_W-1:0] active_b;

    // Selected column intensities and comparator results.
    logic [COLUMN_W-1:0] col_lvl_r;
    logic [COLUMN_W-1:0] col_lvl_g;
    logic [COLUMN_W-1:0] col_lvl_b;
    logic [ROWS-1:0]     lit_r;
    logic [ROWS-1:0]     lit_g;
    logic [ROWS-1:0]     lit_b;
    logic [PWM_BITS-1:0] pwm_step;

    logic drive_now;
    logic first_of_frame;
    logic last_of_frame;

    assign pwm_step       = cnt_p0[PWM_BITS-1:0];
    assign drive_now      = (state_p0 == ST_DRIVE);
    assign first_of_frame = (state_p0 == ST_BLANK) && (cnt_p0 == '0) && (col_p0 == '0);
    assign last_of_frame  = drive_now && (cnt_p0 == DRIVE_LAST) && (col_p0 == COL_LAST);

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= ST_BLANK;
            cnt_p0   <= '0;
            col_p0   <= '0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
            col_p0   <= col_nxt;
        end
    end

    // Sequencer next state: BLANK for BLANK cycles, DRIVE for D cycles, then next column.
    always_comb begin
        state_nxt = state_p0;
        cnt_nxt   = cnt_p0 + 1'b1;
        col_nxt   = col_p0;
        case (state_p0)
            ST_BLANK: begin
                if (cnt_p0 == BLANK_LAST) begin
                    state_nxt = ST_DRIVE;
                    cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_p0 == DRIVE_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    col_nxt   = (col_p0 == COL_LAST) ? '0 : col_p0 + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pick the intensities of the upcoming column out of the active buffer.
    always_comb begin
        col_lvl_r = '0;
        col_lvl_g = '0;
        col_lvl_b = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_p0 == COL_W'(c)) begin
                col_lvl_r = active_r[c*COLUMN_W +: COLUMN_W];
                col_lvl_g = active_g[c*COLUMN_W +: COLUMN_W];
                col_lvl_b = active_b[c*COLUMN_W +: COLUMN_W];
            end
        end
    end

    rgb_matrix_pwm_cmp #(
        .ROWS     (ROWS),
        .PWM_BITS (PWM_BITS)
    ) u_cmp_r (
        .level (col_lvl_r),
        .p     (pwm_step),
        .lit   (lit_r)
    );

    rgb_matrix_pwm_cmp #(
        .ROWS     (ROWS),
        .PWM_BITS (PWM_BITS)
    ) u_cmp_g (
        .level (col_lvl_g),
        .p     (pwm_step),
        .lit   (lit_g)
    );

    rgb_matrix_pwm_cmp #(
        .ROWS     (ROWS),
        .PWM_BITS (PWM_BITS)
    ) u_cmp_b (
        .level (col_lvl_b),
        .p     (pwm_step),
        .lit   (lit_b)
    );

    // Output registers: row drive with polarity, column index and frame markers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r       <= OFF;
            led_g       <= OFF;
            led_b       <= OFF;
            led_com     <= '0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
        end else begin
            led_r       <= drive_now ? (lit_r ^ OFF) : OFF;
            led_g       <= drive_now ? (lit_g ^ OFF) : OFF;
            led_b       <= drive_now ? (lit_b ^ OFF) : OFF;
            led_com     <= col_p0;
            frame_start <= first_of_frame;
            frame_last  <= last_of_frame;
        end
    end

    // Shadow capture; contents only matter while marked full, so no reset.
    always_ff @(posedge clk) begin
        if (pix_valid && pix_ready) begin
            shadow_r <= pix_r;
            shadow_g <= pix_g;
            shadow_b <= pix_b;
        end
    end

    // Handshake and frame-boundary swap. The swap tests the shadow as it was
    // before this edge, so a frame accepted on the boundary waits one frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r  <= '0;
            active_g  <= '0;
            active_b  <= '0;
            pix_ready <= 1'b1;
        end else if (frame_last && !pix_ready) begin
            active_r  <= shadow_r;
            active_g  <= shadow_g;
            active_b  <= shadow_b;
            pix_ready <= 1'b1;
        end else if (pix_valid && pix_ready) begin
            pix_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb_matrix_scanner.sv
// Directed bench for rgb_matrix_scanner: default 8x8x3 instance plus a
// 4-row, 16-column, 2-bit, active-high instance with 2 blanking cycles.
module tb_rgb_matrix_scanner;

    localparam int FW  = 8 * 8 * 3;
    localparam int FW2 = 4 * 16 * 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic          reset;
    logic [FW-1:0] pix_r, pix_g, pix_b;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    led_r, led_g, led_b;
    logic [2:0]    led_com;
    logic          frame_start;

    // Alternate instance
    logic           reset2;
    logic [FW2-1:0] pix_r2, pix_g2, pix_b2;
    logic           pix_valid2;
    logic           pix_ready2;
    logic [3:0]     led_r2, led_g2, led_b2;
    logic [3:0]     led_com2;
    logic           frame_start2;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_matrix_scanner dut (
        .clk         (clk),
        .reset       (reset),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .led_r       (led_r),
        .led_g       (led_g),
        .led_b       (led_b),
        .led_com     (led_com),
        .frame_start (frame_start)
    );

    rgb_matrix_scanner #(
        .ROWS       (4),
        .COLS       (16),
        .PWM_BITS   (2),
        .BLANK      (2),
        .ACTIVE_LOW (0)
    ) dut2 (
        .clk         (clk),
        .reset       (reset2),
        .pix_r       (pix_r2),
        .pix_g       (pix_g2),
        .pix_b       (pix_b2),
        .pix_valid   (pix_valid2),
        .pix_ready   (pix_ready2),
        .led_r       (led_r2),
        .led_g       (led_g2),
        .led_b       (led_b2),
        .led_com     (led_com2),
        .frame_start (frame_start2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Reset values, hold under reset, first cycle after release (ends at k=0).
    task automatic test_reset();
        #2;
        reset  = 1'b1;
        reset2 = 1'b1;
        #1;
        n_tests++;
        if ({led_r, led_g, led_b} !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL reset_leds: got %h want %h", {led_r, led_g, led_b}, 24'hFFFFFF);
        end
        n_tests++;
        if (led_com !== 3'd0) begin
            n_fail++; $display("FAIL reset_com: got %0d want 0", led_com);
        end
        n_tests++;
        if (frame_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_start: got %b want 0", frame_start);
        end
        n_tests++;
        if (pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", pix_ready);
        end
        steps(3);
        n_tests++;
        if ({led_r, led_g, led_b, frame_start} !== {24'hFFFFFF, 1'b0}) begin
            n_fail++; $display("FAIL reset_hold: got %h want %h", {led_r, led_g, led_b, frame_start}, {24'hFFFFFF, 1'b0});
        end
        reset = 1'b0;
        step();
        n_tests++;
        if ({led_r, led_g, led_b, led_com, frame_start} !== {24'hFFFFFF, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL first_cycle: got %h want %h", {led_r, led_g, led_b, led_com, frame_start}, {24'hFFFFFF, 3'd0, 1'b1});
        end
    endtask

    // All pixels level 7: 1 dark cycle then 7 lit cycles per column, 64-cycle frame.
    task automatic test_level7();
        logic [27:0] got, want;
        pix_r = '1; pix_g = '1; pix_b = '1;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        n_tests++;
        if (pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL l7_ready_low: got %b want 0", pix_ready);
        end
        steps(63);
        for (int i = 0; i <= 64; i++) begin
            got  = {led_r, led_g, led_b, led_com, frame_start};
            want = {((i % 8) == 0) ? 24'hFFFFFF : 24'h000000, 3'((i / 8) % 8), ((i % 64) == 0)};
            n_tests++;
            if (got !== want) begin
                n_fail++; $display("FAIL l7_cycle%0d: got %h want %h", i, got, want);
            end
            if (i < 64) step();
        end
    endtask

    // Red (col 2, row 5) = 3: led_r[5] low for p=0..2 only, green/blue dark.
    task automatic test_single_pixel();
        logic [7:0] want_r;
        pix_r = '0; pix_g = '0; pix_b = '0;
        pix_r[63 +: 3] = 3'd3;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        steps(63);
        for (int i = 0; i <= 64; i++) begin
            want_r = (((i / 8) % 8) == 2 && (i % 8) >= 1 && (i % 8) <= 3) ? 8'hDF : 8'hFF;
            n_tests++;
            if ({led_r, led_g, led_b} !== {want_r, 16'hFFFF}) begin
                n_fail++; $display("FAIL pix_cycle%0d: got %h want %h", i, {led_r, led_g, led_b}, {want_r, 16'hFFFF});
            end
            if (i < 64) step();
        end
    endtask

    // Frame B accepted mid-frame while A shows; B appears only after the boundary.
    task automatic test_handshake();
        steps(10);
        pix_r = '1; pix_g = '0; pix_b = '0;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        n_tests++;
        if (pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL hs_ready_low: got %b want 0", pix_ready);
        end
        steps(6);
        n_tests++;
        if ({led_r, led_g} !== 16'hDFFF) begin
            n_fail++; $display("FAIL hs_still_a: got %h want %h", {led_r, led_g}, 16'hDFFF);
        end
        steps(46);
        n_tests++;
        if ({pix_ready, led_com} !== {1'b0, 3'd7}) begin
            n_fail++; $display("FAIL hs_last_cycle: got %h want %h", {pix_ready, led_com}, {1'b0, 3'd7});
        end
        step();
        n_tests++;
        if ({pix_ready, frame_start} !== 2'b11) begin
            n_fail++; $display("FAIL hs_ready_back: got %b want 11", {pix_ready, frame_start});
        end
        steps(17);
        n_tests++;
        if ({led_r, led_g, led_com} !== {8'h00, 8'hFF, 3'd2}) begin
            n_fail++; $display("FAIL hs_shows_b: got %h want %h", {led_r, led_g, led_com}, {8'h00, 8'hFF, 3'd2});
        end
        steps(47);
    endtask

    // pix_valid held with shadow full: first frame (C) swaps in, D waits.
    task automatic test_back_to_back();
        pix_r = '0; pix_g = '0; pix_b = '0;
        pix_g[2:0] = 3'd7;
        pix_valid = 1'b1;
        step();
        n_tests++;
        if (pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_low: got %b want 0", pix_ready);
        end
        pix_g = '0;
        pix_b[2:0] = 3'd7;
        steps(62);
        n_tests++;
        if (pix_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_held_off: got %b want 0", pix_ready);
        end
        step();
        n_tests++;
        if (pix_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_swap_ready: got %b want 1", pix_ready);
        end
        step();
        pix_valid = 1'b0;
        n_tests++;
        if ({pix_ready, led_r, led_g, led_b} !== {1'b0, 8'hFF, 8'hFE, 8'hFF}) begin
            n_fail++; $display("FAIL b2b_shows_c: got %h want %h", {pix_ready, led_r, led_g, led_b}, {1'b0, 8'hFF, 8'hFE, 8'hFF});
        end
        steps(64);
        n_tests++;
        if ({led_r, led_g, led_b} !== {8'hFF, 8'hFF, 8'hFE}) begin
            n_fail++; $display("FAIL b2b_shows_d: got %h want %h", {led_r, led_g, led_b}, {8'hFF, 8'hFF, 8'hFE});
        end
        steps(63);
    endtask

    // Reset during column 4 DRIVE with a pending frame: both buffers discarded.
    task automatic test_reset_mid();
        pix_r = '1; pix_g = '0; pix_b = '0;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        steps(34);
        n_tests++;
        if ({led_com, pix_ready} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL rm_before: got %h want %h", {led_com, pix_ready}, {3'd4, 1'b0});
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({led_r, led_g, led_b, led_com, frame_start, pix_ready} !== {24'hFFFFFF, 3'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rm_immediate: got %h want %h", {led_r, led_g, led_b, led_com, frame_start, pix_ready}, {24'hFFFFFF, 3'd0, 1'b0, 1'b1});
        end
        step();
        step();
        reset = 1'b0;
        step();
        n_tests++;
        if ({frame_start, led_com} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL rm_restart: got %h want %h", {frame_start, led_com}, {1'b1, 3'd0});
        end
        step();
        n_tests++;
        if ({led_r, led_g, led_b} !== 24'hFFFFFF) begin
            n_fail++; $display("FAIL rm_dark: got %h want %h", {led_r, led_g, led_b}, 24'hFFFFFF);
        end
        steps(64);
        n_tests++;
        if ({pix_ready, led_r, led_g, led_b} !== {1'b1, 24'hFFFFFF}) begin
            n_fail++; $display("FAIL rm_shadow_gone: got %h want %h", {pix_ready, led_r, led_g, led_b}, {1'b1, 24'hFFFFFF});
        end
        steps(63);
    endtask

    // Alternate geometry: 5-cycle column, 80-cycle frame, active-high drive.
    task automatic test_alt_params();
        logic [16:0] got, want;
        n_tests++;
        if ({led_r2, led_g2, led_b2, led_com2, frame_start2, pix_ready2} !== {12'h000, 4'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL alt_reset: got %h want %h", {led_r2, led_g2, led_b2, led_com2, frame_start2, pix_ready2}, {12'h000, 4'd0, 1'b0, 1'b1});
        end
        reset2 = 1'b0;
        step();
        n_tests++;
        if ({frame_start2, led_r2} !== {1'b1, 4'h0}) begin
            n_fail++; $display("FAIL alt_first: got %h want %h", {frame_start2, led_r2}, {1'b1, 4'h0});
        end
        pix_r2 = '1; pix_g2 = '0; pix_b2 = '0;
        pix_valid2 = 1'b1;
        step();
        pix_valid2 = 1'b0;
        n_tests++;
        if (pix_ready2 !== 1'b0) begin
            n_fail++; $display("FAIL alt_ready_low: got %b want 0", pix_ready2);
        end
        steps(79);
        for (int i = 0; i <= 80; i++) begin
            got  = {led_r2, led_g2, led_b2, led_com2, frame_start2};
            want = {((i % 5) >= 2) ? 12'hF00 : 12'h000, 4'((i / 5) % 16), ((i % 80) == 0)};
            n_tests++;
            if (got !== want) begin
                n_fail++; $display("FAIL alt_cycle%0d: got %h want %h", i, got, want);
            end
            if (i < 80) step();
        end
    endtask

    initial begin
        reset      = 1'b0;
        reset2     = 1'b0;
        pix_r      = '0; pix_g  = '0; pix_b  = '0;
        pix_r2     = '0; pix_g2 = '0; pix_b2 = '0;
        pix_valid  = 1'b0;
        pix_valid2 = 1'b0;
        test_reset();
        test_level7();
        test_single_pixel();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_alt_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_matrix_scanner.md
RGB_MATRIX_SCANNER -- requirements
Module: rgb_matrix_scanner

Interface
REQ-001 Parameter ROWS, default 8: LED rows per column line; each colour output has this width.
REQ-002 Parameter COLS, default 8: scanned columns per frame; minimum 2.
REQ-003 Parameter PWM_BITS, default 3: intensity bits per pixel per colour; minimum 1.
REQ-004 Parameter BLANK, default 1: blanking cycles before each column drive; minimum 1.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 means lit = 0 on led_r/g/b; 0 means lit = 1.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 pix_r / pix_g / pix_b  in  ROWS*COLS*PWM_BITS each  frame intensities; the pixel at (col c, row r) occupies bits [(c*ROWS+r)*PWM_BITS +: PWM_BITS].
REQ-009 pix_valid  in  1  the pix_* inputs carry a complete new frame.
REQ-010 pix_ready  out  1  the shadow buffer is empty and can accept a frame.
REQ-011 led_r / led_g / led_b  out  ROWS each  row drive for the current column.
REQ-012 led_com  out  clog2(COLS)  index of the selected column.
REQ-013 frame_start  out  1  one-cycle pulse at the start of each frame.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have two states, BLANK and DRIVE.
  - BLANK lasts BLANK cycles.
  - DRIVE lasts D = 2^PWM_BITS-1 cycles.
  - Sequence is BLANK -> DRIVE -> BLANK (next column).
REQ-016 In BLANK, all led_r/g/b bits SHALL be at the off level.
REQ-017 led_com SHALL change only on the first BLANK cycle of a column.
  - It increments modulo COLS.
  - It wraps from COLS-1 to 0.
REQ-018 In DRIVE, the PWM counter p SHALL run 0..D-1, one step per cycle.
REQ-019 During DRIVE cycle p, a row bit SHALL be lit iff the active-buffer intensity for (led_com, row) is > p.
  - Level 0 is never lit.
  - Level D is lit for all D cycles.
  - R, G and B are evaluated independently.
REQ-020 Column period SHALL be BLANK+D cycles; frame period SHALL be COLS*(BLANK+D) cycles.
REQ-021 frame_start SHALL pulse high for exactly one cycle, on the first BLANK cycle of column 0.
REQ-022 Handshake: pix_valid && pix_ready SHALL copy pix_* into the shadow buffer and mark it full.
  - pix_ready = ~shadow_full.
  - pix_* is ignored when pix_ready is low.
REQ-023 On the last DRIVE cycle of column COLS-1, if the shadow buffer is full:
  - the shadow is copied to the active buffer;
  - the shadow is marked empty.
  - Otherwise the active frame repeats unchanged.
REQ-024 If an accept and the frame-end check occur in the same cycle, the shadow was empty at the check, so no swap occurs; the accepted frame SHALL swap at the next frame end.
REQ-025 The active buffer SHALL never change mid-frame, so no tearing occurs.

Reset
REQ-026 On reset assertion, outputs SHALL take these values immediately:
  - led_r/g/b all off (all ones when ACTIVE_LOW=1);
  - led_com=0;
  - frame_start=0;
  - pix_ready=1.
REQ-027 Reset SHALL also set: state=BLANK, cycle counters=0, active buffer all zero, shadow empty.
REQ-028 After reset release, the first cycle SHALL be BLANK for column 0 with frame_start=1.
REQ-029 Reset mid-frame SHALL discard both buffers; no partial column is completed.

Structure
REQ-030 Shared package rgb_matrix_pkg SHALL hold the default parameter values and the state enum (BLANK, DRIVE).
REQ-031 A sub-module rgb_matrix_pwm_cmp SHALL compare one column of ROWS intensities against p, producing ROWS lit bits.
  - It is instantiated once per colour.
  - Output polarity is applied after the comparator.

Verification
REQ-032 Defaults, reset, all pixels level 7 loaded:
  - each column gives 1 cycle all-ones followed by 7 cycles all-zero;
  - led_com runs 0..7 then wraps to 0;
  - frame_start is high every 64 cycles.
REQ-033 Red (col 2, row 5) = level 3, all else 0:
  - during column 2, led_r[5] is 0 for DRIVE cycles p=0..2 and 1 for p=3..6;
  - led_g and led_b stay all-ones.
REQ-034 Frame A is active; frame B is accepted mid-frame:
  - pix_ready goes low;
  - display stays A until the frame boundary, then shows B;
  - pix_ready returns high on the next cycle.
REQ-035 pix_valid held high with the shadow full: the second frame is not accepted until after the swap; the shadow data equals the first frame.
REQ-036 Reset asserted during column 4 DRIVE:
  - outputs are immediately all-ones with led_com=0;
  - after release the display is dark (zero buffer) and pix_ready=1.
REQ-037 ROWS=4, COLS=16, PWM_BITS=2, BLANK=2, ACTIVE_LOW=0:
  - column period is 5 cycles and frame period is 80 cycles;
  - in BLANK the outputs are all-zero;
  - level 3 is lit for 3 cycles per column.
